// File: rtl/pkt_out_rd_sched_if.sv
// Bus bundle for the packet read-out scheduler: command pushes, the two
// packet-RAM read ports, the egress stream and the slot recycle ports.
interface pkt_out_rd_sched_if #(
  parameter int SLOT_AW = 4,
  parameter int LINE_AW = 7
);
  localparam int ADDR_W = SLOT_AW + LINE_AW;

  // Slot descriptors pushed by the buffer manager
  logic               cut_cmd_wr;
  logic [SLOT_AW-1:0] cut_cmd;
  logic               nocut_cmd_wr;
  logic [SLOT_AW-1:0] nocut_cmd;

  // Cut packet RAM read port
  logic               ram_rd;
  logic [ADDR_W-1:0]  ram_rd_addr;
  logic [138:0]       ram_data_q;

  // Nocut packet RAM read port
  logic               nocut_pkt_ram_rd;
  logic [ADDR_W-1:0]  nocut_pkt_ram_rd_addr;
  logic [138:0]       nocut_pkt_ram_data_q;

  // Egress stream and downstream fill level
  logic [138:0]       pkt_out_data;
  logic               pkt_out_valid;
  logic [7:0]         pkt_out_usedw;

  // Slot return ports
  logic [SLOT_AW-1:0] pkt_out_recycle_addr;
  logic               pkt_out_recycle_wr;
  logic [SLOT_AW-1:0] nocutpkt_out_recycle_addr;
  logic               nocutpkt_out_recycle_wr;

  // Status pulses
  logic [1:0]         cmd_ovf;
  logic               trunc_err;

  // Scheduler side
  modport master (
    input  cut_cmd_wr, cut_cmd, nocut_cmd_wr, nocut_cmd,
    input  ram_data_q, nocut_pkt_ram_data_q, pkt_out_usedw,
    output ram_rd, ram_rd_addr, nocut_pkt_ram_rd, nocut_pkt_ram_rd_addr,
    output pkt_out_data, pkt_out_valid,
    output pkt_out_recycle_addr, pkt_out_recycle_wr,
    output nocutpkt_out_recycle_addr, nocutpkt_out_recycle_wr,
    output cmd_ovf, trunc_err
  );

  // Environment side (buffer manager, RAMs, egress FIFO)
  modport slave (
    output cut_cmd_wr, cut_cmd, nocut_cmd_wr, nocut_cmd,
    output ram_data_q, nocut_pkt_ram_data_q, pkt_out_usedw,
    input  ram_rd, ram_rd_addr, nocut_pkt_ram_rd, nocut_pkt_ram_rd_addr,
    input  pkt_out_data, pkt_out_valid,
    input  pkt_out_recycle_addr, pkt_out_recycle_wr,
    input  nocutpkt_out_recycle_addr, nocutpkt_out_recycle_wr,
    input  cmd_ovf, trunc_err
  );
endinterface

// File: rtl/pkt_out_rd_sched.sv
// Read-out scheduler for the cut and nocut packet buffer RAMs.
// Slot descriptors are queued per source in 4-deep FIFOs, arbitrated
// round-robin, and each granted slot is streamed line by line from its RAM to
// the egress port. Reads pause while the egress FIFO is above threshold. The
// packet ends on a tail word (or on the last line of the slot, which is then
// forced to a tail and flagged), after which the slot is returned through the
// source's recycle port. Index 1 of the per-source arrays is cut, 0 is nocut.
module pkt_out_rd_sched #(
  parameter int         SLOT_AW     = 4,
  parameter int         LINE_AW     = 7,
  parameter logic [7:0] FULL_THRESH = 8'd200
) (
  input logic                clk,
  input logic                reset,
  pkt_out_rd_sched_if.master bus
);

  localparam int                 ADDR_W    = SLOT_AW + LINE_AW;
  localparam int                 DEPTH     = 4;
  localparam logic [LINE_AW-1:0] LAST_LINE = {LINE_AW{1'b1}};
  localparam logic [LINE_AW-1:0] LINE_ONE  = {{(LINE_AW-1){1'b0}}, 1'b1};
  localparam logic [2:0]         TAG_TAIL  = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    RECYCLE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Command FIFO storage and status
  logic [SLOT_AW-1:0] fifo_mem  [2][DEPTH];
  logic [1:0]         wr_ptr    [2];
  logic [1:0]         rd_ptr    [2];
  logic [2:0]         count     [2];
  logic [SLOT_AW-1:0] push_data [2];
  logic [SLOT_AW-1:0] head      [2];
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [1:0]         accept;
  logic [1:0]         not_empty;
  logic [1:0]         full;
  logic [1:0]         ovf;

  // Arbitration and packet context
  logic               grant;
  logic               gsel;
  logic               below_thresh;
  logic [SLOT_AW-1:0] slot;
  logic [LINE_AW-1:0] line;
  logic               src;
  logic               last_src;
  logic               stop_issue;
  logic               issue;

  // Return path
  logic               rd_d1;
  logic               last_d1;
  logic [138:0]       q_sel;
  logic               q_live;
  logic               q_tail;
  logic               pkt_end;
  logic               trunc_now;

  // Registered outputs
  logic [138:0]       out_data;
  logic               out_valid;
  logic               out_trunc;
  logic [SLOT_AW-1:0] cut_rcy_addr;
  logic               cut_rcy_wr;
  logic [SLOT_AW-1:0] nocut_rcy_addr;
  logic               nocut_rcy_wr;

  // FIFO occupancy flags and head-of-queue descriptors
  always_comb begin
    push         = {bus.cut_cmd_wr, bus.nocut_cmd_wr};
    push_data[1] = bus.cut_cmd;
    push_data[0] = bus.nocut_cmd;
    below_thresh = (bus.pkt_out_usedw <= FULL_THRESH);
    for (int i = 0; i < 2; i++) begin
      not_empty[i] = (count[i] != 3'd0);
      full[i]      = (count[i] == 3'd4);
      head[i]      = fifo_mem[i][rd_ptr[i]];
    end
  end

  // A push into a full FIFO is only taken when a pop frees a slot that cycle
  always_comb begin
    accept = 2'b00;
    for (int i = 0; i < 2; i++) begin
      accept[i] = push[i] & (~full[i] | pop[i]);
    end
  end

  // Qualify returning RAM data: only words from a read issued last cycle count
  always_comb begin
    q_sel     = src ? bus.ram_data_q : bus.nocut_pkt_ram_data_q;
    q_live    = rd_d1 && (state == READ);
    q_tail    = (q_sel[138:136] == TAG_TAIL);
    pkt_end   = q_live && (q_tail || last_d1);
    trunc_now = q_live && last_d1 && !q_tail;
  end

  // Next-state, grant selection and read-issue decision
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gsel      = 1'b0;
    pop       = 2'b00;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if ((|not_empty) && below_thresh) begin
          grant     = 1'b1;
          gsel      = (&not_empty) ? ~last_src : not_empty[1];
          pop       = gsel ? 2'b10 : 2'b01;
          state_nxt = READ;
        end else begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        // A tail on the return path cancels the read that would follow it
        issue = below_thresh && !stop_issue && !(q_live && q_tail);
        if (pkt_end) begin
          state_nxt = RECYCLE;
        end else begin
          state_nxt = READ;
        end
      end
      RECYCLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read strobes go only to the RAM of the source being serviced
  always_comb begin
    bus.ram_rd                = issue && src;
    bus.nocut_pkt_ram_rd      = issue && !src;
    bus.ram_rd_addr           = src ? {slot, line} : {ADDR_W{1'b0}};
    bus.nocut_pkt_ram_rd_addr = src ? {ADDR_W{1'b0}} : {slot, line};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO pointers, fill counts and the overflow pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= 2'd0;
        rd_ptr[i] <= 2'd0;
        count[i]  <= 3'd0;
      end
      ovf <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 2'd1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 2'd1;
        end
        case ({accept[i], pop[i]})
          2'b10:   count[i] <= count[i] + 3'd1;
          2'b01:   count[i] <= count[i] - 3'd1;
          default: count[i] <= count[i];
        endcase
        ovf[i] <= push[i] & ~accept[i];
      end
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) begin
        fifo_mem[i][wr_ptr[i]] <= push_data[i];
      end
    end
  end

  // Latch the granted descriptor and advance the line pointer as reads issue
  always_ff @(posedge clk) begin
    if (reset) begin
      slot       <= {SLOT_AW{1'b0}};
      line       <= {LINE_AW{1'b0}};
      src        <= 1'b0;
      last_src   <= 1'b0;
      stop_issue <= 1'b0;
      rd_d1      <= 1'b0;
      last_d1    <= 1'b0;
    end else begin
      rd_d1   <= issue;
      last_d1 <= issue && (line == LAST_LINE);
      if (grant) begin
        slot       <= gsel ? head[1] : head[0];
        src        <= gsel;
        line       <= {LINE_AW{1'b0}};
        stop_issue <= 1'b0;
      end else if (issue) begin
        line <= line + LINE_ONE;
        if (line == LAST_LINE) begin
          stop_issue <= 1'b1;
        end
      end
      // Clearing last_src after reset leaves the cut source favoured
      if (state == RECYCLE) begin
        last_src <= src;
      end
    end
  end

  // Egress word, truncation flag and slot recycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data       <= 139'd0;
      out_valid      <= 1'b0;
      out_trunc      <= 1'b0;
      cut_rcy_addr   <= {SLOT_AW{1'b0}};
      cut_rcy_wr     <= 1'b0;
      nocut_rcy_addr <= {SLOT_AW{1'b0}};
      nocut_rcy_wr   <= 1'b0;
    end else begin
      out_valid    <= q_live;
      out_trunc    <= trunc_now;
      cut_rcy_wr   <= pkt_end && src;
      nocut_rcy_wr <= pkt_end && !src;
      if (q_live) begin
        out_data <= trunc_now ? {TAG_TAIL, q_sel[135:0]} : q_sel;
      end
      if (pkt_end && src) begin
        cut_rcy_addr <= slot;
      end
      if (pkt_end && !src) begin
        nocut_rcy_addr <= slot;
      end
    end
  end

  // Drive the registered results onto the bus
  always_comb begin
    bus.pkt_out_data              = out_data;
    bus.pkt_out_valid             = out_valid;
    bus.trunc_err                 = out_trunc;
    bus.cmd_ovf                   = ovf;
    bus.pkt_out_recycle_addr      = cut_rcy_addr;
    bus.pkt_out_recycle_wr        = cut_rcy_wr;
    bus.nocutpkt_out_recycle_addr = nocut_rcy_addr;
    bus.nocutpkt_out_recycle_wr   = nocut_rcy_wr;
  end

endmodule

// File: tb/tb_pkt_out_rd_sched.sv
// Bench for pkt_out_rd_sched: behavioural RAMs with programmable packet
// lengths, a scoreboard of expected egress words and recycle events, and
// directed cycle checks for latency, backpressure, overflow and reset.
module tb_pkt_out_rd_sched;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pkt_out_rd_sched_if bus ();

  pkt_out_rd_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [138:0] data;
    logic         trunc;
    logic         last;
    logic         src;
    logic [3:0]   slot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ovf_cut_cnt = 0;
  int   ovf_nocut_cnt = 0;
  int   len_tab [2][16];

  // Compare one observed value against its expectation
  task automatic check_eq(input string tag, input logic [138:0] act, input logic [138:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // RAM content: head on line 0, tail on line len-1, len 0 means no tail at all
  function automatic logic [138:0] mk_word(input logic src, input logic [10:0] addr);
    logic [2:0] tag;
    int         len;
    len = len_tab[src][addr[10:7]];
    if (addr[6:0] == 7'd0) tag = 3'b101;
    else if (len != 0 && int'(addr[6:0]) == len - 1) tag = 3'b110;
    else tag = 3'b100;
    return {tag, src, addr, {10{addr}}, 14'h0};
  endfunction

  // Queue expected egress words of a packet; n_out 0 means the whole packet
  task automatic expect_pkt(input logic src, input logic [3:0] slot, input int n_out);
    exp_t e;
    int   len;
    int   total;
    int   n;
    len   = len_tab[src][slot];
    total = (len == 0) ? 128 : len;
    n     = (n_out == 0) ? total : n_out;
    for (int i = 0; i < n; i++) begin
      e.data  = mk_word(src, {slot, 7'(i)});
      e.trunc = 1'b0;
      e.last  = (i == total - 1);
      e.src   = src;
      e.slot  = slot;
      if (len == 0 && i == 127) begin
        e.data[138:136] = 3'b110;
        e.trunc         = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cut(input logic [3:0] slot);
    tick();
    bus.cut_cmd_wr = 1'b1;
    bus.cut_cmd    = slot;
    tick();
    bus.cut_cmd_wr = 1'b0;
  endtask

  // Wait until the scoreboard empties, then let the FSM return to idle
  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_eq("drain", 139'(exp_q.size()), 139'(0));
    repeat (2) tick();
  endtask

  // Wait for a cut RAM read of a given line
  task automatic wait_rd(input logic [6:0] ln, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ram_rd && bus.ram_rd_addr[6:0] == ln) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("wait_rd", 139'(found), 139'(1));
  endtask

  // Behavioural RAMs with one cycle read latency
  always @(posedge clk) begin
    if (bus.ram_rd) bus.ram_data_q <= mk_word(1'b1, bus.ram_rd_addr);
    if (bus.nocut_pkt_ram_rd) bus.nocut_pkt_ram_data_q <= mk_word(1'b0, bus.nocut_pkt_ram_rd_addr);
  end

  // Egress monitor: pop and compare words, recycle pulses and trunc flag
  always @(negedge clk) begin
    exp_t e;
    if (bus.cmd_ovf[1]) ovf_cut_cnt++;
    if (bus.cmd_ovf[0]) ovf_nocut_cnt++;
    if (bus.ram_rd || bus.nocut_pkt_ram_rd)
      check_eq("strobe_excl", 139'(bus.ram_rd & bus.nocut_pkt_ram_rd), 139'(0));
    if (bus.pkt_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_out", bus.pkt_out_data, 139'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", bus.pkt_out_data, e.data);
        check_eq("trunc_err", 139'(bus.trunc_err), 139'(e.trunc));
        if (e.last) begin
          check_eq("rcy_wr", 139'({bus.pkt_out_recycle_wr, bus.nocutpkt_out_recycle_wr}),
                   e.src ? 139'(2'b10) : 139'(2'b01));
          check_eq("rcy_addr", e.src ? 139'(bus.pkt_out_recycle_addr) : 139'(bus.nocutpkt_out_recycle_addr),
                   139'(e.slot));
        end else begin
          check_eq("rcy_mid", 139'({bus.pkt_out_recycle_wr, bus.nocutpkt_out_recycle_wr}), 139'(0));
        end
      end
    end else if (bus.trunc_err || bus.pkt_out_recycle_wr || bus.nocutpkt_out_recycle_wr) begin
      check_eq("stray_pulse", 139'({bus.trunc_err, bus.pkt_out_recycle_wr, bus.nocutpkt_out_recycle_wr}), 139'(0));
    end
  end

  // Absolute time limit
  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    bus.cut_cmd_wr = 1'b0;
    bus.cut_cmd = 4'd0;
    bus.nocut_cmd_wr = 1'b0;
    bus.nocut_cmd = 4'd0;
    bus.pkt_out_usedw = 8'd0;
    bus.ram_data_q = 139'd0;
    bus.nocut_pkt_ram_data_q = 139'd0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 16; k++) len_tab[s][k] = 4;
    len_tab[1][1]  = 3;
    len_tab[0][5]  = 4;
    len_tab[1][2]  = 2;
    len_tab[0][6]  = 3;
    len_tab[1][3]  = 3;
    len_tab[1][5]  = 10;
    len_tab[1][6]  = 0;
    len_tab[1][0]  = 30;
    len_tab[1][13] = 5;
    len_tab[1][4]  = 3;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 139'(bus.pkt_out_valid), 139'(0));
    check_eq("rst_data", bus.pkt_out_data, 139'(0));
    check_eq("rst_rd", 139'({bus.ram_rd, bus.nocut_pkt_ram_rd}), 139'(0));
    check_eq("rst_rcy", 139'({bus.pkt_out_recycle_wr, bus.nocutpkt_out_recycle_wr}), 139'(0));
    check_eq("rst_flags", 139'({bus.cmd_ovf, bus.trunc_err}), 139'(0));

    // Round robin: cut favoured from reset, sources alternate
    tick();
    bus.cut_cmd_wr = 1'b1;   bus.cut_cmd = 4'd1;
    bus.nocut_cmd_wr = 1'b1; bus.nocut_cmd = 4'd5;
    expect_pkt(1'b1, 4'd1, 0);
    expect_pkt(1'b0, 4'd5, 0);
    expect_pkt(1'b1, 4'd2, 0);
    expect_pkt(1'b0, 4'd6, 0);
    tick();
    bus.cut_cmd = 4'd2;
    bus.nocut_cmd = 4'd6;
    tick();
    bus.cut_cmd_wr = 1'b0;
    bus.nocut_cmd_wr = 1'b0;
    drain(300);

    // Latency and addressing of a 3-line cut packet in slot 3
    tick();
    bus.cut_cmd_wr = 1'b1;
    bus.cut_cmd = 4'd3;
    expect_pkt(1'b1, 4'd3, 0);
    tick();
    bus.cut_cmd_wr = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        check_eq("t1_rd", 139'(bus.ram_rd), 139'(1));
        check_eq("t1_addr", 139'(bus.ram_rd_addr), 139'(11'h180 + 11'(c - 2)));
      end
      check_eq("t1_nocut_rd", 139'(bus.nocut_pkt_ram_rd), 139'(0));
      check_eq("t1_valid", 139'(bus.pkt_out_valid), 139'(c >= 4));
      if (c == 6) begin
        check_eq("t1_rcy_wr", 139'(bus.pkt_out_recycle_wr), 139'(1));
        check_eq("t1_rcy_addr", 139'(bus.pkt_out_recycle_addr), 139'(3));
      end
    end
    drain(50);

    // Backpressure pause of 5 cycles mid-packet
    send_cut(4'd5);
    expect_pkt(1'b1, 4'd5, 0);
    wait_rd(7'd3, 20);
    tick();
    bus.pkt_out_usedw = 8'd201;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t3_pause_rd", 139'({bus.ram_rd, bus.nocut_pkt_ram_rd}), 139'(0));
      if (k < 4) tick();
    end
    tick();
    bus.pkt_out_usedw = 8'd0;
    @(negedge clk);
    check_eq("t3_resume_rd", 139'(bus.ram_rd), 139'(1));
    check_eq("t3_resume_addr", 139'(bus.ram_rd_addr), 139'({4'd5, 7'd4}));
    drain(100);

    // Slot with no tail: truncated at line 127
    send_cut(4'd6);
    expect_pkt(1'b1, 4'd6, 0);
    drain(400);

    // Command overflow while a long packet streams
    send_cut(4'd0);
    expect_pkt(1'b1, 4'd0, 0);
    wait_rd(7'd1, 20);
    ovf_cut_cnt = 0;
    ovf_nocut_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.cut_cmd_wr = 1'b1;
      bus.cut_cmd = 4'(7 + k);
    end
    tick();
    bus.cut_cmd_wr = 1'b0;
    for (int k = 0; k < 4; k++) expect_pkt(1'b1, 4'(7 + k), 0);
    repeat (2) tick();
    check_eq("t5_ovf_cut", 139'(ovf_cut_cnt), 139'(2));
    check_eq("t5_ovf_nocut", 139'(ovf_nocut_cnt), 139'(0));
    drain(400);

    // Reset in the middle of a 5-line packet
    send_cut(4'd13);
    expect_pkt(1'b1, 4'd13, 1);
    wait_rd(7'd2, 20);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("t6_valid", 139'(bus.pkt_out_valid), 139'(0));
    check_eq("t6_rd", 139'({bus.ram_rd, bus.nocut_pkt_ram_rd}), 139'(0));
    check_eq("t6_rcy", 139'({bus.pkt_out_recycle_wr, bus.nocutpkt_out_recycle_wr}), 139'(0));
    check_eq("t6_sb", 139'(exp_q.size()), 139'(0));
    repeat (10) tick();
    send_cut(4'd4);
    expect_pkt(1'b1, 4'd4, 0);
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
